lfsr_way_sel: RTL and testbench

Parametrised pseudo-random way selector built on a maximal-length XNOR LFSR of configurable width. It serves cache-refill and arbitration victim selection over any number of ways, not only powers of two. An availability mask restricts the pick. The block retries with a bounded number of attempts, then falls back deterministically, and returns each selection through a valid/ready handshake. It sits beside the cache controller's refill FSM and can be re-seeded at run time.

---
 rtl/lfsr_way_sel.sv | 180 ++++++++++++++++++
 tb/tb_lfsr_way_sel.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_way_sel.sv
// Pseudo-random victim/way selector: XNOR LFSR candidates filtered by an
// availability mask, bounded retries with lowest-index fallback, valid/ready output.
module lfsr_way_sel #(
    parameter int unsigned          LfsrWidth = 8,
    parameter logic [LfsrWidth-1:0] Seed      = '0,
    parameter int unsigned          NumWays   = 8,
    parameter int unsigned          MaxTries  = 4,
    localparam int unsigned         LogWays   = $clog2(NumWays)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 seed_load_i,
    input  logic [LfsrWidth-1:0] seed_i,
    input  logic                 en_i,
    input  logic                 req_i,
    input  logic [NumWays-1:0]   avail_i,
    output logic                 sel_valid_o,
    input  logic                 sel_ready_i,
    output logic [NumWays-1:0]   sel_oh_o,
    output logic [LogWays-1:0]   sel_bin_o,
    output logic                 sel_fallback_o,
    output logic                 none_avail_o,
    output logic [LfsrWidth-1:0] state_o
);

    if (LfsrWidth < 4 || LfsrWidth > 16) begin : g_bad_width
        $error("lfsr_way_sel: LfsrWidth must be in 4..16");
    end
    if (Seed == {LfsrWidth{1'b1}}) begin : g_bad_seed
        $error("lfsr_way_sel: all-ones Seed is the XNOR lock-up state");
    end
    if (NumWays < 2 || NumWays > (32'd1 << LfsrWidth)) begin : g_bad_ways
        $error("lfsr_way_sel: NumWays must be in 2..2^LfsrWidth");
    end
    if (MaxTries < 1) begin : g_bad_tries
        $error("lfsr_way_sel: MaxTries must be at least 1");
    end

    // Tap n maps to bit n-1 of the state.
    function automatic logic [15:0] tap_mask(input int unsigned w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]          TapsFull = tap_mask(LfsrWidth);
    localparam logic [LfsrWidth-1:0] Taps     = TapsFull[LfsrWidth-1:0];
    localparam int unsigned          ExtWays  = 32'd1 << LogWays;
    localparam int unsigned          TryW     = $clog2(MaxTries) + 1;
    localparam logic [TryW-1:0]      LastTry  = TryW'(MaxTries - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VALID
    } fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [LfsrWidth-1:0] lfsr_q, lfsr_d;
    logic [NumWays-1:0]   avail_q, avail_d;
    logic [TryW-1:0]      tries_q, tries_d;
    logic [NumWays-1:0]   sel_oh_q, sel_oh_d;
    logic [LogWays-1:0]   sel_bin_q, sel_bin_d;
    logic                 fb_q, fb_d;

    logic                 lfsr_fb;
    logic [LogWays-1:0]   cand;
    logic [ExtWays-1:0]   avail_ext;
    logic [ExtWays-1:0]   cand_oh_ext;
    logic                 cand_hit;
    logic [LogWays-1:0]   low_idx;
    logic [NumWays-1:0]   low_oh;

    assign lfsr_fb = ~^(lfsr_q & Taps);

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = (&seed_i) ? '0 : seed_i;
        end else if (en_i || fsm_q == SEARCH) begin
            lfsr_d = {lfsr_q[LfsrWidth-2:0], lfsr_fb};
        end
    end

    // Candidates past NumWays land on the zero padding and therefore never hit.
    assign cand        = lfsr_q[LogWays-1:0];
    assign avail_ext   = ExtWays'(avail_q);
    assign cand_oh_ext = ExtWays'(1) << cand;
    assign cand_hit    = avail_ext[cand];
    assign low_oh      = avail_q & (~avail_q + NumWays'(1));

    always_comb begin
        low_idx = '0;
        for (int unsigned i = NumWays; i > 0; i--) begin
            if (avail_q[i-1]) begin
                low_idx = LogWays'(i - 1);
            end
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        avail_d   = avail_q;
        tries_d   = tries_q;
        sel_oh_d  = sel_oh_q;
        sel_bin_d = sel_bin_q;
        fb_d      = fb_q;
        case (fsm_q)
            IDLE: begin
                if (req_i && |avail_i) begin
                    avail_d = avail_i;
                    tries_d = '0;
                    fsm_d   = SEARCH;
                end
            end
            SEARCH: begin
                if (cand_hit) begin
                    sel_bin_d = cand;
                    sel_oh_d  = cand_oh_ext[NumWays-1:0];
                    fb_d      = 1'b0;
                    fsm_d     = VALID;
                end else if (tries_q == LastTry) begin
                    sel_bin_d = low_idx;
                    sel_oh_d  = low_oh;
                    fb_d      = 1'b1;
                    fsm_d     = VALID;
                end else begin
                    tries_d = tries_q + TryW'(1);
                end
            end
            VALID: begin
                if (sel_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q     <= IDLE;
            lfsr_q    <= Seed;
            avail_q   <= '0;
            tries_q   <= '0;
            sel_oh_q  <= '0;
            sel_bin_q <= '0;
            fb_q      <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            lfsr_q    <= lfsr_d;
            avail_q   <= avail_d;
            tries_q   <= tries_d;
            sel_oh_q  <= sel_oh_d;
            sel_bin_q <= sel_bin_d;
            fb_q      <= fb_d;
        end
    end

    assign sel_valid_o    = (fsm_q == VALID);
    assign sel_oh_o       = sel_oh_q;
    assign sel_bin_o      = sel_bin_q;
    assign sel_fallback_o = fb_q;
    assign none_avail_o   = (fsm_q == IDLE) && req_i && !(|avail_i);
    assign state_o        = lfsr_q;

endmodule

// File: tb/tb_lfsr_way_sel.sv
// Bench for lfsr_way_sel: an 8-way and a 6-way instance share stimulus and are
// checked against a transaction-level model of candidate search and fallback.
module tb_lfsr_way_sel;

    logic       clk = 1'b0;
    logic       rst, seed_load, en, req, ready;
    logic [7:0] seed, avail;
    logic [5:0] avail6;

    logic       a_valid, a_fb, a_none;
    logic [7:0] a_oh, a_state;
    logic [2:0] a_bin;
    logic       b_valid, b_fb, b_none;
    logic [5:0] b_oh;
    logic [7:0] b_state;
    logic [2:0] b_bin;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;
    assign avail6 = avail[5:0];

    lfsr_way_sel #(.LfsrWidth(8), .Seed(8'h00), .NumWays(8), .MaxTries(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .seed_load_i(seed_load), .seed_i(seed), .en_i(en),
        .req_i(req), .avail_i(avail), .sel_valid_o(a_valid), .sel_ready_i(ready),
        .sel_oh_o(a_oh), .sel_bin_o(a_bin), .sel_fallback_o(a_fb),
        .none_avail_o(a_none), .state_o(a_state)
    );

    lfsr_way_sel #(.LfsrWidth(8), .Seed(8'h00), .NumWays(6), .MaxTries(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .seed_load_i(seed_load), .seed_i(seed), .en_i(en),
        .req_i(req), .avail_i(avail6), .sel_valid_o(b_valid), .sel_ready_i(ready),
        .sel_oh_o(b_oh), .sel_bin_o(b_bin), .sel_fallback_o(b_fb),
        .none_avail_o(b_none), .state_o(b_state)
    );

    // Maximal-length XNOR sequence: feedback is 1 when an even number of taps are set.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int taps[4] = '{8, 6, 5, 4};
        int ones = 0;
        foreach (taps[i]) ones += int'(s[taps[i]-1]);
        return {s[6:0], (ones % 2 == 0)};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
        logic [7:0] r = s;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    // Latency counted from the accept cycle (cycle 0) to the first valid cycle.
    function automatic void predict(input int ways, input logic [7:0] s0, input logic [7:0] av,
                                    output int lat, output int sel, output bit fb);
        int span = 1 << $clog2(ways);
        logic [7:0] s = s0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = int'(s) % span;
            if (c < ways && av[c]) begin
                lat = k + 2; sel = c; fb = 1'b0;
                return;
            end
            s = lfsr_next(s);
        end
        lat = 5; fb = 1'b1; sel = 0;
        for (int i = ways - 1; i >= 0; i--) if (av[i]) sel = i;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; seed_load = 1'b0; en = 1'b0; req = 1'b0; ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_load = 1'b1; seed = s;
        step();
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; req = 1'b1; avail = 8'hFF;
        repeat (3) step();
        do_reset();
        avail = 8'h00;
        vectors++; if (a_state !== 8'h00) begin errors++; $display("FAIL reset_state: got %h expected 00", a_state); end
        vectors++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", a_valid, b_valid); end
        vectors++; if (a_oh !== 8'h00 || a_bin !== 3'd0 || a_fb !== 1'b0) begin errors++; $display("FAIL reset_sel: got oh=%h bin=%0d fb=%b expected 00/0/0", a_oh, a_bin, a_fb); end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_seq [7] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        logic [7:0] m = 8'h3D;
        int ret = 0;
        bit saw_ff = 1'b0;
        do_reset();
        en = 1'b1;
        for (int i = 1; i < 7; i++) begin
            step();
            vectors++; if (a_state !== exp_seq[i]) begin errors++; $display("FAIL free_run_seq[%0d]: got %h expected %h", i, a_state, exp_seq[i]); end
        end
        for (int n = 7; n <= 300 && ret == 0; n++) begin
            step();
            m = lfsr_next(m);
            vectors++; if (a_state !== m) begin errors++; $display("FAIL free_run_model[%0d]: got %h expected %h", n, a_state, m); end
            if (a_state === 8'hFF) saw_ff = 1'b1;
            if (a_state === 8'h00) ret = n;
        end
        vectors++; if (ret !== 255) begin errors++; $display("FAIL free_run_period: got %0d expected 255", ret); end
        vectors++; if (saw_ff !== 1'b0) begin errors++; $display("FAIL free_run_lockup: got %b expected 0", saw_ff); end
        en = 1'b0;
    endtask

    task automatic test_all_ones_seed();
        en = 1'b1;
        step();
        seed_load = 1'b1; seed = 8'hFF;
        step();
        seed_load = 1'b0; en = 1'b0;
        vectors++; if (a_state !== 8'h00 || b_state !== 8'h00) begin errors++; $display("FAIL all_ones_seed: got %h/%h expected 00/00", a_state, b_state); end
    endtask

    task automatic test_hit_pow2();
        do_reset();
        req = 1'b1; avail = 8'hFF;
        step();
        req = 1'b0; avail = 8'h00;
        vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL hit_cycle1_valid: got %b expected 0", a_valid); end
        step();
        vectors++; if (a_valid !== 1'b1 || a_bin !== 3'd0 || a_oh !== 8'h01 || a_fb !== 1'b0)
            begin errors++; $display("FAIL hit_cycle2: got v=%b bin=%0d oh=%h fb=%b expected 1/0/01/0", a_valid, a_bin, a_oh, a_fb); end
        req = 1'b1; avail = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (a_valid !== 1'b1 || a_bin !== 3'd0 || a_oh !== 8'h01 || a_fb !== 1'b0)
                begin errors++; $display("FAIL hit_hold[%0d]: got v=%b bin=%0d oh=%h fb=%b expected 1/0/01/0", i, a_valid, a_bin, a_oh, a_fb); end
        end
        req = 1'b0; ready = 1'b1;
        step();
        ready = 1'b0;
        vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL hit_after_ready: got %b expected 0", a_valid); end
    endtask

    task automatic test_fallback();
        do_reset();
        req = 1'b1; avail = 8'h40;
        step();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL fallback_early_valid[%0d]: got %b expected 0", c, a_valid); end
            step();
        end
        vectors++; if (a_valid !== 1'b1 || a_bin !== 3'd6 || a_oh !== 8'h40 || a_fb !== 1'b1)
            begin errors++; $display("FAIL fallback_sel: got v=%b bin=%0d oh=%h fb=%b expected 1/6/40/1", a_valid, a_bin, a_oh, a_fb); end
        vectors++; if (a_state !== 8'h0F) begin errors++; $display("FAIL fallback_state: got %h expected 0F", a_state); end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_non_pow2();
        do_reset();
        load_seed(8'h07);
        req = 1'b1; avail = 8'hFF;
        step();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            vectors++; if (b_valid !== 1'b0) begin errors++; $display("FAIL npow2_early_valid[%0d]: got %b expected 0", c, b_valid); end
            step();
        end
        vectors++; if (b_valid !== 1'b1 || b_bin !== 3'd5 || b_oh !== 6'h20 || b_fb !== 1'b0)
            begin errors++; $display("FAIL npow2_sel: got v=%b bin=%0d oh=%h fb=%b expected 1/5/20/0", b_valid, b_bin, b_oh, b_fb); end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_none_avail();
        do_reset();
        req = 1'b1; avail = 8'h00;
        #1;
        vectors++; if (a_none !== 1'b1 || b_none !== 1'b1) begin errors++; $display("FAIL none_avail_comb: got %b/%b expected 1/1", a_none, b_none); end
        step();
        vectors++; if (a_valid !== 1'b0 || a_none !== 1'b1) begin errors++; $display("FAIL none_avail_idle: got v=%b none=%b expected 0/1", a_valid, a_none); end
        req = 1'b0;
        #1;
        vectors++; if (a_none !== 1'b0) begin errors++; $display("FAIL none_avail_noreq: got %b expected 0", a_none); end
        req = 1'b1; avail = 8'h01;
        #1;
        vectors++; if (a_none !== 1'b0) begin errors++; $display("FAIL none_avail_avail: got %b expected 0", a_none); end
        req = 1'b0;
        repeat (3) step();
        vectors++; if (a_valid !== 1'b0) begin errors++; $display("FAIL none_avail_novalid: got %b expected 0", a_valid); end
    endtask

    task automatic test_reset_mid_search();
        do_reset();
        req = 1'b1; avail = 8'h40;
        step();
        req = 1'b0;
        repeat (4) step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        load_seed(8'h00);
        req = 1'b1; avail = 8'h40;
        step();
        req = 1'b0;
        step();
        vectors++; if (a_state !== 8'h01) begin errors++; $display("FAIL midsearch_pre_state: got %h expected 01", a_state); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (a_valid !== 1'b0 || a_oh !== 8'h00 || a_bin !== 3'd0 || a_fb !== 1'b0 || a_state !== 8'h00)
            begin errors++; $display("FAIL midsearch_reset: got v=%b oh=%h bin=%0d fb=%b st=%h expected 0/00/0/0/00", a_valid, a_oh, a_bin, a_fb, a_state); end
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (a_valid !== 1'b0 || a_state !== 8'h00) begin errors++; $display("FAIL midsearch_dropped[%0d]: got v=%b st=%h expected 0/00", i, a_valid, a_state); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 40; t++) begin
            logic [7:0] s, ms, av, ma, mb;
            int lat_a, sel_a, lat_b, sel_b, maxlat, nh;
            bit fb_a, fb_b;
            s = 8'($urandom);
            if (t % 10 == 3) s = 8'hFF;
            load_seed(s);
            ms = (s == 8'hFF) ? 8'h00 : s;
            vectors++; if (a_state !== ms || b_state !== ms) begin errors++; $display("FAIL rnd_seed[%0d]: got %h/%h expected %h", t, a_state, b_state, ms); end
            do av = 8'($urandom); while (av[5:0] == 6'd0);
            predict(8, ms, av, lat_a, sel_a, fb_a);
            predict(6, ms, av & 8'h3F, lat_b, sel_b, fb_b);
            maxlat = (lat_a > lat_b) ? lat_a : lat_b;
            req = 1'b1; avail = av;
            step();
            for (int cyc = 1; cyc <= maxlat; cyc++) begin
                vectors++; if (a_valid !== (cyc >= lat_a) || b_valid !== (cyc >= lat_b))
                    begin errors++; $display("FAIL rnd_latency[%0d] cyc %0d: got %b/%b expected %b/%b", t, cyc, a_valid, b_valid, cyc >= lat_a, cyc >= lat_b); end
                if (cyc < maxlat) begin
                    req = 1'($urandom); avail = 8'($urandom);
                    step();
                end
            end
            req = 1'b0;
            ma = lfsr_adv(ms, lat_a - 1);
            mb = lfsr_adv(ms, lat_b - 1);
            vectors++; if (a_bin !== 3'(sel_a) || a_oh !== 8'(1 << sel_a) || a_fb !== fb_a)
                begin errors++; $display("FAIL rnd_sel_a[%0d]: got bin=%0d oh=%h fb=%b expected %0d/%h/%b", t, a_bin, a_oh, a_fb, sel_a, 8'(1 << sel_a), fb_a); end
            vectors++; if (b_bin !== 3'(sel_b) || b_oh !== 6'(1 << sel_b) || b_fb !== fb_b)
                begin errors++; $display("FAIL rnd_sel_b[%0d]: got bin=%0d oh=%h fb=%b expected %0d/%h/%b", t, b_bin, b_oh, b_fb, sel_b, 6'(1 << sel_b), fb_b); end
            nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++) begin
                en = 1'($urandom);
                step();
                if (en) begin ma = lfsr_next(ma); mb = lfsr_next(mb); end
                vectors++; if (a_valid !== 1'b1 || b_valid !== 1'b1 || a_bin !== 3'(sel_a) || b_bin !== 3'(sel_b) || a_state !== ma || b_state !== mb)
                    begin errors++; $display("FAIL rnd_hold[%0d.%0d]: got v=%b/%b bin=%0d/%0d st=%h/%h expected 1/1 %0d/%0d %h/%h", t, h, a_valid, b_valid, a_bin, b_bin, a_state, b_state, sel_a, sel_b, ma, mb); end
            end
            en = 1'b0; ready = 1'b1;
            step();
            ready = 1'b0;
            vectors++; if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_state !== ma || b_state !== mb)
                begin errors++; $display("FAIL rnd_release[%0d]: got v=%b/%b st=%h/%h expected 0/0 %h/%h", t, a_valid, b_valid, a_state, b_state, ma, mb); end
        end
    endtask

    initial begin
        rst = 1'b1; seed_load = 1'b0; seed = 8'h00; en = 1'b0;
        req = 1'b0; ready = 1'b0; avail = 8'h00;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_free_run();
        test_all_ones_seed();
        test_hit_pow2();
        test_fallback();
        test_non_pow2();
        test_none_avail();
        test_reset_mid_search();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
